// File: rtl/div_pkg.sv
// Shared types for the iterative divider: op encoding, FSM states
// and small op-decoding helpers.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ITER  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } div_state_e;

  function automatic logic is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/lzc.sv
// Combinational leading-zero counter; all-zero input yields WIDTH.
// Ports: value (WIDTH bits) in, count ($clog2(WIDTH)+1 bits) out.
module lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]       value,
  output logic [$clog2(WIDTH):0] count
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic found;

  always_comb begin
    count = CW'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = CW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU) with tag.
// Ports: clock, nreset, in valid/ready + op/a/b/tag, flush_i,
//        out valid/ready + result_o/tag_o.
import div_pkg::*;

module iter_divider #(
  parameter int WIDTH     = 32,
  parameter int EARLY_OUT = 1,
  parameter int TAG_W     = 5
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int LW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e state;
  div_state_e state_next;

  div_op_e          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] da;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    idx;
  logic             sign_a;
  logic             sign_b;

  logic             accept;
  logic             sgn;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [CW-1:0]    lz;
  logic [CW-1:0]    n;
  logic             is_dz;
  logic             is_ovf;
  logic             skip;

  logic             bit_in;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   db_x;
  logic             ge;
  logic [WIDTH:0]   rem_n;

  logic [WIDTH-1:0] q_sel;
  logic [WIDTH-1:0] r_sel;
  logic [WIDTH-1:0] res_sel;

  // The partial remainder never exceeds |b|, so its top bit only
  // exists to hold the shifted-in trial value.
  logic unused_rem_msb;
  assign unused_rem_msb = rem[WIDTH];

  assign accept = in_valid_i && in_ready_o && !flush_i;

  assign sgn    = is_signed(op_q);
  assign neg_a  = sgn && a_q[WIDTH-1];
  assign neg_b  = sgn && b_q[WIDTH-1];
  assign abs_a  = neg_a ? -a_q : a_q;
  assign abs_b  = neg_b ? -b_q : b_q;
  assign is_dz  = (b_q == '0);
  assign is_ovf = sgn && (a_q == MIN) && (b_q == '1);

  lzc #(
    .WIDTH(WIDTH)
  ) u_lzc (
    .value(abs_a),
    .count(lz)
  );

  assign n    = (EARLY_OUT != 0) ? CW'(WIDTH) - lz : CW'(WIDTH);
  assign skip = (n == '0) || is_dz || is_ovf;

  assign bit_in = da[idx[LW-1:0]];
  assign trial  = {rem[WIDTH-1:0], bit_in};
  assign db_x   = {1'b0, db};
  assign ge     = (trial >= db_x);
  assign rem_n  = ge ? trial - db_x : trial;

  always_comb begin
    q_sel = (sign_a ^ sign_b) ? -quo : quo;
    r_sel = sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    if (is_dz) begin
      q_sel = '1;
      r_sel = a_q;
    end else if (is_ovf) begin
      q_sel = MIN;
      r_sel = '0;
    end
    res_sel = is_rem(op_q) ? r_sel : q_sel;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = PREP;
      PREP:    state_next = skip ? FIXUP : ITER;
      ITER:    if (idx == '0) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DONE:    if (out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      op_q        <= DIV;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      da          <= '0;
      db          <= '0;
      quo         <= '0;
      rem         <= '0;
      idx         <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      tag_o       <= '0;
    end else begin
      if (state == IDLE && accept) begin
        op_q  <= div_op_e'(op_i);
        a_q   <= a_i;
        b_q   <= b_i;
        tag_q <= tag_i;
      end
      if (state == PREP) begin
        da     <= abs_a;
        db     <= abs_b;
        sign_a <= neg_a;
        sign_b <= neg_b;
        quo    <= '0;
        rem    <= '0;
        idx    <= n - CW'(1);
      end
      if (state == ITER) begin
        rem               <= rem_n;
        quo[idx[LW-1:0]]  <= ge;
        idx               <= idx - CW'(1);
      end
      if (state == FIXUP && !flush_i) begin
        result_o <= res_sel;
        tag_o    <= tag_q;
      end
      in_ready_o  <= (state_next == IDLE);
      out_valid_o <= (state_next == DONE);
    end
  end

endmodule
